// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and
// architectural constants used by the fetch unit and its environment.
package if_pkg;

  // Fetch FSM states: no request outstanding, one request outstanding,
  // or one outstanding response that must be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Head is read combinationally so decode sees it in the same cycle it becomes
// valid; flush clears the occupancy in one cycle. Pointers wrap naturally
// because DEPTH is a power of two.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage write; contents need no reset since the head is qualified by count.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues at most one instruction-memory request at a
// time, buffers returned instructions with their PC, and discards responses
// that belong to a flushed (branched-away) path.
// Optional build macro IF_ALIGN_CHECK_EN: adds id_misalign_o; misaligned PCs
// are buffered with a NOP instruction instead of being sent to memory.
module if_fetch
  import if_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              fetch_stall_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [31:0]       id_instr_o,
  output logic [ADDR_W-1:0] id_pc_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic              id_misalign_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = ADDR_W + 32;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pending_pc_q;

  logic [CW-1:0] count;
  logic [CW-1:0] occ_after;
  logic [DW-1:0] head;
  logic [DW-1:0] push_data;
  logic          id_valid;
  logic          pop;
  logic          rsp_push;
  logic          misalign_push;
  logic          push;
  logic          slot_free;
  logic          handshake;
  logic          pc_misaligned;

`ifdef IF_ALIGN_CHECK_EN
  assign pc_misaligned = |pc_i[1:0];
`else
  assign pc_misaligned = 1'b0;
`endif

  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready_i;
  assign rsp_push = (state_q == WAIT) & imem_rvalid_i & ~flush_i;

  // Occupancy after this cycle's pop and response push. A new request only
  // goes out if this leaves room, so its response can always be accepted
  // (only pops can happen while it is outstanding).
  assign occ_after = count - CW'(pop) + CW'(rsp_push);
  assign slot_free = rsta_n & pc_valid_i & ~flush_i & (occ_after < CW'(FIFO_DEPTH));

  assign imem_req_o    = slot_free & ~pc_misaligned & ((state_q == IDLE) | rsp_push);
  assign imem_addr_o   = pc_i;
  assign handshake     = imem_req_o & imem_gnt_i;
  assign misalign_push = slot_free & pc_misaligned & (state_q == IDLE);
  assign fetch_stall_o = rsta_n & pc_valid_i & ~(handshake | misalign_push);

  assign push      = rsp_push | misalign_push;
  assign push_data = misalign_push ? {pc_i, NOP_INSTR} : {pending_pc_q, imem_rdata_i};

  // Request/response tracking: one outstanding request, flushed responses dropped.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q      <= IDLE;
      pending_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            state_q      <= WAIT;
            pending_pc_q <= pc_i;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state_q <= imem_rvalid_i ? IDLE : DROP;
          end else if (imem_rvalid_i) begin
            if (handshake) begin
              state_q      <= WAIT;
              pending_pc_q <= pc_i;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DROP: begin
          if (imem_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk_i   (clka),
    .rst_ni  (rsta_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_o  (head),
    .count_o (count)
  );

  assign id_valid_o = id_valid;
  assign id_instr_o = id_valid ? head[31:0] : NOP_INSTR;
  assign id_pc_o    = id_valid ? head[DW-1:32] : '0;
`ifdef IF_ALIGN_CHECK_EN
  assign id_misalign_o = id_valid & (|head[33:32]);
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the bench plays instruction memory, queues the
// {pc, instr} pairs that decode should see, and a monitor checks deliveries.
module tb_if_fetch;
  import if_pkg::*;

  logic        clka;
  logic        rsta_n;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        fetch_stall_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        id_misalign_o;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  if_fetch #(.FIFO_DEPTH(2), .ADDR_W(32)) dut (
    .clka          (clka),
    .rsta_n        (rsta_n),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .fetch_stall_o (fetch_stall_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .id_misalign_o (id_misalign_o)
`endif
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Scoreboard consumer: every accepted decode transfer must match the queue head.
  always @(negedge clka) begin
    logic [63:0] e;
    if (rsta_n === 1'b1 && id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_delivery observed=0x%0h expected=none", {id_pc_o, id_instr_o});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deliver", {id_pc_o, id_instr_o}, e);
`ifdef IF_ALIGN_CHECK_EN
        chk("deliver_misalign", {63'd0, id_misalign_o}, {63'd0, |e[33:32]});
`endif
        $display("[TB] delivered pc=0x%08h instr=0x%08h", id_pc_o, id_instr_o);
      end
    end
  end

  initial begin
    logic [31:0] pcv;
    logic [31:0] dv;

    // Reset state, with the PC stage already presenting a valid address
    rsta_n = 1'b0; pc_i = RESET_PC; pc_valid_i = 1'b1; flush_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b1;
    repeat (2) @(posedge clka);
    #2;
    chk("rst_req",   {63'd0, imem_req_o},    64'd0);
    chk("rst_stall", {63'd0, fetch_stall_o}, 64'd0);
    chk("rst_valid", {63'd0, id_valid_o},    64'd0);
    chk("rst_instr", {32'd0, id_instr_o},    64'd0);
    chk("rst_pc",    {32'd0, id_pc_o},       64'd0);

    // Basic fetch: grant now, response next cycle, delivery the cycle after
    tick();
    rsta_n = 1'b1; pc_i = RESET_PC; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    #1;
    chk("s1_req",   {63'd0, imem_req_o},    64'd1);
    chk("s1_addr",  {32'd0, imem_addr_o},   {32'd0, RESET_PC});
    chk("s1_stall", {63'd0, fetch_stall_o}, 64'd0);
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0011_2233;
    exp_q.push_back({RESET_PC, 32'h0011_2233});
    #1;
    chk("s1_not_early", {63'd0, id_valid_o}, 64'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("s1_valid", {63'd0, id_valid_o}, 64'd1);

    // Grant withheld for three cycles: stall, stable address, nothing buffered
    tick();
    pc_i = RESET_PC + 32'h4; pc_valid_i = 1'b1; imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s2_stall", {63'd0, fetch_stall_o}, 64'd1);
      chk("s2_addr",  {32'd0, imem_addr_o},   {32'd0, RESET_PC + 32'h4});
      chk("s2_nopush", {63'd0, id_valid_o},   64'd0);
      tick();
    end
    imem_gnt_i = 1'b1;
    #1;
    chk("s2_grant_stall", {63'd0, fetch_stall_o}, 64'd0);
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA5A5_0004;
    exp_q.push_back({RESET_PC + 32'h4, 32'hA5A5_0004});
    tick();
    imem_rvalid_i = 1'b0;

    // Decode stalled: two entries buffered, third request held until a pop
    tick();
    id_ready_i = 1'b0; pc_i = RESET_PC; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1000_0000; pc_i = RESET_PC + 32'h4;
    exp_q.push_back({RESET_PC, 32'h1000_0000});
    #1;
    chk("s3_req2",   {63'd0, imem_req_o},    64'd1);
    chk("s3_stall2", {63'd0, fetch_stall_o}, 64'd0);
    tick();
    imem_rdata_i = 32'h1000_0004; pc_i = RESET_PC + 32'h8;
    exp_q.push_back({RESET_PC + 32'h4, 32'h1000_0004});
    #1;
    chk("s3_req3_held", {63'd0, imem_req_o},    64'd0);
    chk("s3_stall3",    {63'd0, fetch_stall_o}, 64'd1);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("s3_full_stall", {63'd0, fetch_stall_o}, 64'd1);
    chk("s3_full_req",   {63'd0, imem_req_o},    64'd0);
    chk("s3_full_valid", {63'd0, id_valid_o},    64'd1);
    tick();
    #1;
    chk("s3_hold_stall", {63'd0, fetch_stall_o}, 64'd1);
    tick();
    id_ready_i = 1'b1;
    #1;
    chk("s3_pop_req",   {63'd0, imem_req_o},    64'd1);
    chk("s3_pop_stall", {63'd0, fetch_stall_o}, 64'd0);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1000_0008; imem_gnt_i = 1'b0; pc_valid_i = 1'b0;
    exp_q.push_back({RESET_PC + 32'h8, 32'h1000_0008});
    tick();
    imem_rvalid_i = 1'b0;

    // Flush while a request is outstanding: buffer emptied, late response dropped
    tick();
    id_ready_i = 1'b0; pc_i = RESET_PC + 32'hC; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0055; pc_i = RESET_PC + 32'h10;
    tick();
    imem_rvalid_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("s4_flush_req",   {63'd0, imem_req_o},    64'd0);
    chk("s4_flush_stall", {63'd0, fetch_stall_o}, 64'd1);
    tick();
    flush_i = 1'b0; pc_i = RESET_PC + 32'h100; id_ready_i = 1'b1;
    #1;
    chk("s4_emptied",  {63'd0, id_valid_o},    64'd0);
    chk("s4_drop_req", {63'd0, imem_req_o},    64'd0);
    chk("s4_drop_stall", {63'd0, fetch_stall_o}, 64'd1);
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("s4_drop_req2", {63'd0, imem_req_o}, 64'd0);
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("s4_no_deadbeef", {63'd0, id_valid_o}, 64'd0);
    chk("s4_refetch_req", {63'd0, imem_req_o}, 64'd1);
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    exp_q.push_back({RESET_PC + 32'h100, 32'h0000_0013});
    tick();
    imem_rvalid_i = 1'b0;

    // Asynchronous reset in the middle of an outstanding request
    tick();
    id_ready_i = 1'b0; pc_i = RESET_PC + 32'h200; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0077; pc_i = RESET_PC + 32'h204;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    chk("s5_buffered", {63'd0, id_valid_o}, 64'd1);
    #1;
    rsta_n = 1'b0;
    #1;
    chk("s5_async_valid", {63'd0, id_valid_o},    64'd0);
    chk("s5_async_instr", {32'd0, id_instr_o},    64'd0);
    chk("s5_async_pc",    {32'd0, id_pc_o},       64'd0);
    chk("s5_async_req",   {63'd0, imem_req_o},    64'd0);
    chk("s5_async_stall", {63'd0, fetch_stall_o}, 64'd0);
    tick();
    tick();
    rsta_n = 1'b1; pc_i = RESET_PC + 32'h300; pc_valid_i = 1'b1; imem_gnt_i = 1'b1; id_ready_i = 1'b1;
    #1;
    chk("s5_clean_req", {63'd0, imem_req_o}, 64'd1);
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0099;
    exp_q.push_back({RESET_PC + 32'h300, 32'h0000_0099});
    tick();
    imem_rvalid_i = 1'b0;

    // Back-to-back fetches: one instruction per cycle once the pipe is primed
    tick();
    pc_i = RESET_PC + 32'h400; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      pcv = RESET_PC + 32'h400 + 32'(4 * (i - 1));
      dv  = 32'hC000_0000 + 32'(i);
      imem_rvalid_i = 1'b1; imem_rdata_i = dv;
      exp_q.push_back({pcv, dv});
      if (i < 4) pc_i = RESET_PC + 32'h400 + 32'(4 * i);
      else pc_valid_i = 1'b0;
      #1;
      if (i < 4) chk("s6_b2b_req", {63'd0, imem_req_o}, 64'd1);
      if (i >= 2) chk("s6_b2b_valid", {63'd0, id_valid_o}, 64'd1);
    end
    tick();
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
    #1;
    chk("s6_last_valid", {63'd0, id_valid_o}, 64'd1);

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned PC: buffered with a NOP and flagged, no memory request
    tick();
    pc_i = RESET_PC + 32'h2; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    exp_q.push_back({RESET_PC + 32'h2, NOP_INSTR});
    #1;
    chk("s7_mis_noreq", {63'd0, imem_req_o},    64'd0);
    chk("s7_mis_stall", {63'd0, fetch_stall_o}, 64'd0);
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0;
    #1;
    chk("s7_mis_valid", {63'd0, id_valid_o},    64'd1);
    chk("s7_mis_flag",  {63'd0, id_misalign_o}, 64'd1);
`endif

    tick();
    tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
